wb_interconnect_2_slaves: RTL
=============================

WB_INTERCONNECT_2_SLAVES -- requirements
Module: wb_interconnect_2_slaves

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: stb-without-ack cycles before a forced error termination.
REQ-002 SHALL have parameter ADDR_S0, default 8'h00: i_m_adr[31:24] value selecting slave 0.
REQ-003 SHALL have parameter ADDR_S1, default 8'h01: i_m_adr[31:24] value selecting slave 1.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_m_we, i_m_cyc, i_m_stb  in  1 each; i_m_sel  in  4; i_m_adr, i_m_dat  in  32  master request.
REQ-007 o_m_ack  out  1; o_m_dat  out  32; o_m_int  out  1  master response and interrupt.
REQ-008 o_m_err  out  1  sticky bus error: decode miss or timeout.
REQ-009 o_sN_we, o_sN_stb, o_sN_cyc  out  1 each; o_sN_sel  out  4; o_sN_adr, o_sN_dat  out  32; for N=0,1.
REQ-010 i_sN_dat  in  32; i_sN_ack, i_sN_int  in  1 each; for N=0,1.

Function
REQ-011 SHALL implement FSM states IDLE, ACTIVE, ERR_ACK.
REQ-012 IDLE: on i_m_cyc&i_m_stb, SHALL latch slave select from i_m_adr[31:24]; match -> ACTIVE, no match -> ERR_ACK.
REQ-013 ACTIVE: selected slave outputs SHALL mirror master we/stb/cyc/sel/adr/dat combinationally; unselected slave outputs SHALL be 0.
REQ-014 Decode latency: slave stb SHALL first assert in the cycle after master stb is first seen in IDLE.
REQ-015 ACTIVE: o_m_ack SHALL equal the selected slave ack and o_m_dat its data, combinationally; ack from the unselected slave SHALL be ignored.
REQ-016 ACTIVE -> IDLE on the cycle after any ack (slave or forced), or immediately when i_m_cyc deasserts without ack.
REQ-017 Timeout counter SHALL clear on entering ACTIVE and increment each ACTIVE cycle with stb high and no ack; at TIMEOUT_CYCLES it SHALL drive o_m_ack=1, o_m_dat=0 for one cycle, deassert slave stb/cyc, set o_m_err, go to IDLE.
REQ-018 ERR_ACK: SHALL drive o_m_ack=1, o_m_dat=0 for exactly one cycle, set o_m_err, no slave strobed, then IDLE.
REQ-019 o_m_err SHALL clear at the next IDLE acceptance of a new cyc&stb.
REQ-020 Outside ACTIVE, o_m_dat SHALL be 0 except as in REQ-017/018.
REQ-021 o_m_int SHALL be registered (i_s0_int | i_s1_int), one-cycle latency, independent of FSM state.
REQ-022 Slave ack arriving in the same cycle the timeout expires SHALL win: normal data returned, o_m_err not set.
REQ-023 Master dropping cyc mid-transfer SHALL return FSM to IDLE next cycle with slave cyc/stb deasserted that cycle.

Reset
REQ-024 On rst: FSM=IDLE, counter=0, select cleared, o_m_err=0, o_m_int=0, all slave outputs 0, o_m_ack=0, o_m_dat=0.
REQ-025 rst mid-transaction SHALL abandon it without any ack to the master.

Structure
REQ-026 FSM state encodings and the error-data constant (32'h0) SHALL live in the shared wishbone package.
REQ-027 Timeout counter SHALL be a sub-module wb_timeout_counter (clear, enable, expired pulse).

Verification
REQ-028 Write adr=0x00000010 dat=0xA5A5A5A5, s0 acks after 3 cycles -> only s0 strobed (1-cycle delay), m_ack same cycle as s0 ack, err=0.
REQ-029 Read adr=0x01000004, s1 returns 0x12345678 -> o_m_dat=0x12345678 with ack; s0 stb never high.
REQ-030 Access adr=0x7F000000 -> one-cycle ack, o_m_dat=0, o_m_err=1, no slave strobed; next valid access clears err.
REQ-031 TIMEOUT_CYCLES=8, s0 never acks -> forced ack on the 8th stall cycle, o_m_err=1; s0 ack on that same cycle instead -> normal data, err=0.
REQ-032 Assert i_s1_int -> o_m_int high one cycle later; rst during ACTIVE -> all outputs 0 next cycle, no ack.

Source files
------------

// File: rtl/wb_interconnect_2_slaves_pkg.sv
// Shared Wishbone definitions: FSM encodings, error-termination data, address decode.
package wb_interconnect_2_slaves_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_ERR_ACK = 2'd2;

    localparam logic [31:0] ERR_DATA = 32'h0;

    typedef struct packed {
        logic hit;
        logic sel;
    } decode_t;

    // Slave 0 takes priority if both tags are configured identically.
    function automatic decode_t decode_slave(input logic [7:0] tag,
                                             input logic [7:0] tag_s0,
                                             input logic [7:0] tag_s1);
        decode_t d;
        d.hit = 1'b1;
        d.sel = 1'b0;
        if (tag == tag_s0)      d.sel = 1'b0;
        else if (tag == tag_s1) d.sel = 1'b1;
        else                    d.hit = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/wb_interconnect_2_slaves_if.sv
// One Wishbone link: request fields flow master->slave, ack/read data/interrupt flow back.
interface wb_interconnect_2_slaves_if;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        irq;

    modport master (output we, cyc, stb, sel, adr, dat_w, input dat_r, ack, irq);
    modport slave  (input we, cyc, stb, sel, adr, dat_w, output dat_r, ack, irq);
endinterface

// File: rtl/wb_interconnect_2_slaves_timeout_counter.sv
// Stall counter: expired_o pulses combinationally on the LIMIT-th enabled cycle since clear.
// Holds at its final value until cleared; no backpressure of its own.
module wb_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)                 cnt_d = '0;
        else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/wb_interconnect_2_slaves.sv
// 1-master/2-slave Wishbone decoder: one-cycle decode, then combinational pass-through until ack;
// decode misses and stalled slaves are terminated with a zero-data ack and sticky o_m_err.
module wb_interconnect_2_slaves
    import wb_interconnect_2_slaves_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ADDR_S0        = 8'h00,
    parameter logic [7:0]  ADDR_S1        = 8'h01
) (
    input  logic                        clk,
    input  logic                        rst,
    wb_interconnect_2_slaves_if.slave   m,
    wb_interconnect_2_slaves_if.master  s0,
    wb_interconnect_2_slaves_if.master  s1,
    output logic                        o_m_err
);

    logic [1:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic        err_q, err_d;
    logic        int_q;
    logic        req, active, slv_ack, tmo_en, tmo_exp;
    logic        fwd, fwd0, fwd1;
    logic [31:0] slv_dat;
    decode_t     dec;

    assign req     = m.cyc & m.stb;
    assign active  = (state_q == ST_ACTIVE);
    assign dec     = decode_slave(m.adr[31:24], ADDR_S0, ADDR_S1);
    assign slv_ack = sel_q ? s1.ack   : s0.ack;
    assign slv_dat = sel_q ? s1.dat_r : s0.dat_r;

    // A slave ack in the expiry cycle suppresses the timeout because it removes the enable.
    assign tmo_en  = active & m.cyc & m.stb & ~slv_ack;

    wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (~active),
        .en_i      (tmo_en),
        .expired_o (tmo_exp)
    );

    assign fwd  = ~rst & active & m.cyc & ~tmo_exp;
    assign fwd0 = fwd & ~sel_q;
    assign fwd1 = fwd &  sel_q;

    assign s0.we    = fwd0 & m.we;
    assign s0.cyc   = fwd0;
    assign s0.stb   = fwd0 & m.stb;
    assign s0.sel   = fwd0 ? m.sel   : '0;
    assign s0.adr   = fwd0 ? m.adr   : '0;
    assign s0.dat_w = fwd0 ? m.dat_w : '0;

    assign s1.we    = fwd1 & m.we;
    assign s1.cyc   = fwd1;
    assign s1.stb   = fwd1 & m.stb;
    assign s1.sel   = fwd1 ? m.sel   : '0;
    assign s1.adr   = fwd1 ? m.adr   : '0;
    assign s1.dat_w = fwd1 ? m.dat_w : '0;

    assign m.irq   = int_q;
    assign o_m_err = err_q;

    always_comb begin
        m.ack   = 1'b0;
        m.dat_r = ERR_DATA;
        if (!rst) begin
            if (fwd) begin
                m.ack   = slv_ack;
                m.dat_r = slv_dat;
            end else if ((active && tmo_exp) || state_q == ST_ERR_ACK) begin
                m.ack   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    sel_d   = dec.sel;
                    err_d   = ~dec.hit;
                    state_d = dec.hit ? ST_ACTIVE : ST_ERR_ACK;
                end
            end
            ST_ACTIVE: begin
                if (!m.cyc || slv_ack) begin
                    state_d = ST_IDLE;
                end else if (tmo_exp) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_ERR_ACK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            int_q   <= s0.irq | s1.irq;
        end
    end

endmodule
